// File: rtl/xbar_batch_scheduler.sv
// xbar_batch_scheduler: drains one latched batch of PE packets to accumulate-buffer banks with per-bank round-robin
// Ports:
//   clock_i, reset_i      clock and synchronous active-high reset
//   in_valid_i/index/data per-source packets, sampled only while idle
//   busy_o                high while a batch is draining
//   dst_ready_i           per-bank accept strobe
//   out_valid/index/data  registered per-bank packet outputs
//   batch_cycles_o        drain length of the last finished batch (saturating)
module xbar_batch_scheduler #(
    parameter int NUM_SRC = 4,
    parameter int NUM_DST = 4,
    parameter int DATA_W  = 16,
    parameter int INDEX_W = 8
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic [NUM_SRC-1:0]         in_valid_i,
    input  logic [NUM_SRC*INDEX_W-1:0] in_index_i,
    input  logic [NUM_SRC*DATA_W-1:0]  in_data_i,
    output logic                       busy_o,
    input  logic [NUM_DST-1:0]         dst_ready_i,
    output logic [NUM_DST-1:0]         out_valid_o,
    output logic [NUM_DST*INDEX_W-1:0] out_index_o,
    output logic [NUM_DST*DATA_W-1:0]  out_data_o,
    output logic [7:0]                 batch_cycles_o
);
    localparam int DST_W = $clog2(NUM_DST);
    localparam int SRC_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    typedef enum logic {IDLE, DRAIN} state_t;
    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [INDEX_W-1:0]   idx_q [NUM_SRC];
    logic [DATA_W-1:0]    data_q [NUM_SRC];
    logic [SRC_W-1:0]     ptr_q [NUM_DST];
    logic [NUM_DST-1:0]   gnt_v;
    logic [SRC_W-1:0]     gnt_s [NUM_DST];
    logic [SRC_W-1:0]     s;
    logic [7:0]           cyc_q, cyc_inc, batch_cycles_q;
    logic [NUM_DST-1:0]   out_valid_q;
    logic [NUM_DST*INDEX_W-1:0] out_index_q;
    logic [NUM_DST*DATA_W-1:0]  out_data_q;
    assign busy_o         = state_q == DRAIN;
    assign out_valid_o    = out_valid_q;
    assign out_index_o    = out_index_q;
    assign out_data_o     = out_data_q;
    assign batch_cycles_o = batch_cycles_q;
    assign cyc_inc        = cyc_q == 8'hFF ? cyc_q : cyc_q + 8'd1;
    always_comb begin
        gnt_v     = '0;
        s         = '0;
        pending_d = pending_q;
        state_d   = state_q;
        for (int d = 0; d < NUM_DST; d++) gnt_s[d] = '0;
        // scan sources starting at the bank's pointer; first eligible wins
        for (int d = 0; d < NUM_DST; d++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                s = SRC_W'((int'(ptr_q[d]) + k) % NUM_SRC);
                if (state_q == DRAIN && dst_ready_i[d] && !gnt_v[d] && pending_q[s]
                    && idx_q[s][DST_W-1:0] == DST_W'(d)) begin
                    gnt_v[d] = 1'b1;
                    gnt_s[d] = s;
                end
            end
        end
        for (int d = 0; d < NUM_DST; d++) if (gnt_v[d]) pending_d[gnt_s[d]] = 1'b0;
        if (state_q == IDLE && |in_valid_i) begin
            pending_d = in_valid_i;
            state_d   = DRAIN;
        end else if (state_q == DRAIN && pending_d == '0) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            pending_q      <= '0;
            cyc_q          <= '0;
            batch_cycles_q <= '0;
            out_valid_q    <= '0;
            out_index_q    <= '0;
            out_data_q     <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                idx_q[i]  <= '0;
                data_q[i] <= '0;
            end
            for (int d = 0; d < NUM_DST; d++) ptr_q[d] <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            out_valid_q <= gnt_v;
            for (int d = 0; d < NUM_DST; d++) begin
                if (gnt_v[d]) begin
                    out_index_q[d*INDEX_W +: INDEX_W] <= idx_q[gnt_s[d]];
                    out_data_q[d*DATA_W +: DATA_W]    <= data_q[gnt_s[d]];
                    ptr_q[d] <= SRC_W'((int'(gnt_s[d]) + 1) % NUM_SRC);
                end
            end
            if (state_q == IDLE && |in_valid_i) begin
                cyc_q <= '0;
                for (int i = 0; i < NUM_SRC; i++) begin
                    idx_q[i]  <= in_index_i[i*INDEX_W +: INDEX_W];
                    data_q[i] <= in_data_i[i*DATA_W +: DATA_W];
                end
            end
            if (state_q == DRAIN) begin
                cyc_q <= cyc_inc;
                if (state_d == IDLE) batch_cycles_q <= cyc_inc;
            end
        end
    end
endmodule

// File: tb/tb_xbar_batch_scheduler.sv
// tb_xbar_batch_scheduler: directed stimulus with per-bank scoreboard queues checked by a negedge monitor
module tb_xbar_batch_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_valid = '0;
    logic [31:0] in_index = '0;
    logic [63:0] in_data = '0;
    logic [3:0]  dst_ready = 4'hF;
    logic        busy;
    logic [3:0]  out_valid;
    logic [31:0] out_index;
    logic [63:0] out_data;
    logic [7:0]  batch_cycles;
    int checks = 0, errors = 0, m_checks = 0, m_errors = 0;
    logic [23:0] exp_q [4][$];
    logic [23:0] e, g;

    always #5 clk = ~clk;

    xbar_batch_scheduler dut (
        .clock_i(clk), .reset_i(rst), .in_valid_i(in_valid), .in_index_i(in_index),
        .in_data_i(in_data), .busy_o(busy), .dst_ready_i(dst_ready), .out_valid_o(out_valid),
        .out_index_o(out_index), .out_data_o(out_data), .batch_cycles_o(batch_cycles)
    );

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 4; d++) begin
                if (out_valid[d]) begin
                    m_checks++;
                    g = {out_index[d*8 +: 8], out_data[d*16 +: 16]};
                    if (exp_q[d].size() == 0) begin
                        m_errors++;
                        $display("FAIL bank%0d unexpected packet got idx=%0d data=%h", d, g[23:16], g[15:0]);
                    end else begin
                        e = exp_q[d].pop_front();
                        if (g != e) begin
                            m_errors++;
                            $display("FAIL bank%0d packet got idx=%0d data=%h exp idx=%0d data=%h",
                                     d, g[23:16], g[15:0], e[23:16], e[15:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic push(int d, logic [7:0] i, logic [15:0] dat);
        exp_q[d].push_back({i, dat});
    endtask

    task automatic issue(logic [3:0] v, logic [31:0] idx, logic [63:0] dat);
        in_valid = v;
        in_index = idx;
        in_data  = dat;
        @(posedge clk);
        #1 in_valid = '0;
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, int'(busy), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_bc", int'(batch_cycles), 0);
        chk("rst_idx", int'(out_index), 0);
        chk("rst_data", int'(out_data == '0), 1);
        @(posedge clk); #1;
        // no conflict: one packet per bank, one drain cycle
        push(0, 8'd0, 16'h1111); push(1, 8'd1, 16'h2222);
        push(2, 8'd2, 16'h3333); push(3, 8'd3, 16'h4444);
        issue(4'hF, {8'd3, 8'd2, 8'd1, 8'd0}, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
        @(negedge clk);
        chk("t2_busy", int'(busy), 1);
        @(negedge clk);
        chk("t2_busy_drop", int'(busy), 0);
        chk("t2_valid", int'(out_valid), 15);
        chk("t2_bc", int'(batch_cycles), 1);
        @(posedge clk); #1;
        // batch A leaves ptr[2]=2
        push(2, 8'd6, 16'hA000); push(2, 8'd6, 16'hA001);
        issue(4'b0011, {8'd0, 8'd0, 8'd6, 8'd6}, {16'h0, 16'h0, 16'hA001, 16'hA000});
        wait_idle("t3a");
        chk("t3a_bc", int'(batch_cycles), 2);
        @(posedge clk); #1;
        // batch B: all to bank 2, served src2,src3,src0,src1
        push(2, 8'd10, 16'hB002); push(2, 8'd14, 16'hB003);
        push(2, 8'd2, 16'hB000);  push(2, 8'd6, 16'hB001);
        issue(4'hF, {8'd14, 8'd10, 8'd6, 8'd2}, {16'hB003, 16'hB002, 16'hB001, 16'hB000});
        wait_idle("t3b");
        chk("t3b_bc", int'(batch_cycles), 4);
        @(posedge clk); #1;
        // backpressure on bank 1 for three drain cycles
        dst_ready = 4'b1101;
        push(1, 8'd5, 16'h5555);
        issue(4'b0010, {8'd0, 8'd0, 8'd5, 8'd0}, {16'h0, 16'h0, 16'h5555, 16'h0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_busy_held", int'(busy), 1);
            chk("t4_no_valid", int'(out_valid[1]), 0);
            @(posedge clk);
        end
        #1 dst_ready = 4'hF;
        @(negedge clk);
        chk("t4_not_yet", int'(out_valid[1]), 0);
        @(posedge clk);
        @(negedge clk);
        chk("t4_valid", int'(out_valid[1]), 1);
        chk("t4_idle", int'(busy), 0);
        chk("t4_bc", int'(batch_cycles), 4);
        @(posedge clk); #1;
        // new inputs during drain must be ignored
        dst_ready = 4'b1110;
        push(0, 8'd4, 16'h7777);
        issue(4'b0001, {8'd0, 8'd0, 8'd0, 8'd4}, {16'h0, 16'h0, 16'h0, 16'h7777});
        in_valid = 4'hF;
        in_index = {8'd3, 8'd2, 8'd1, 8'd0};
        in_data  = {4{16'h9999}};
        @(posedge clk);
        #1 in_valid = '0;
        dst_ready = 4'hF;
        @(negedge clk);
        chk("t5_busy", int'(busy), 1);
        @(posedge clk);
        @(negedge clk);
        chk("t5_idle", int'(busy), 0);
        chk("t5_bc", int'(batch_cycles), 2);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("t5_quiet_valid", int'(out_valid), 0);
            chk("t5_quiet_busy", int'(busy), 0);
        end
        @(posedge clk); #1;
        // partial mask: only src0 and src2, both to bank 3
        push(3, 8'd3, 16'hC000); push(3, 8'd7, 16'hC002);
        issue(4'b0101, {8'd3, 8'd7, 8'd3, 8'd3}, {16'hC003, 16'hC002, 16'hC001, 16'hC000});
        wait_idle("t6");
        chk("t6_bc", int'(batch_cycles), 2);
        @(posedge clk); #1;
        // reset mid-drain discards the batch and clears pointers
        dst_ready = 4'h0;
        issue(4'hF, {8'd3, 8'd2, 8'd1, 8'd0}, {4{16'hDDDD}});
        @(negedge clk);
        chk("t1_pre_busy", int'(busy), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        dst_ready = 4'hF;
        @(negedge clk);
        chk("t1_busy", int'(busy), 0);
        chk("t1_valid", int'(out_valid), 0);
        chk("t1_bc", int'(batch_cycles), 0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("t1_discard_valid", int'(out_valid), 0);
            chk("t1_discard_busy", int'(busy), 0);
        end
        @(posedge clk); #1;
        // ptr[0] back at 0: bank 0 serves src0..src3 in order
        push(0, 8'd0, 16'hE000); push(0, 8'd4, 16'hE001);
        push(0, 8'd8, 16'hE002); push(0, 8'd12, 16'hE003);
        issue(4'hF, {8'd12, 8'd8, 8'd4, 8'd0}, {16'hE003, 16'hE002, 16'hE001, 16'hE000});
        wait_idle("t1_after");
        chk("t1_after_bc", int'(batch_cycles), 4);
        @(negedge clk); #1;
        for (int d = 0; d < 4; d++) chk($sformatf("bank%0d_leftover", d), exp_q[d].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks + m_checks, errors + m_errors);
        $finish;
    end
endmodule
